// File: rtl/wbc_vic.sv
// wbc_vic: vectored-interrupt responder for the CPU VIRQ/ISTB/IACK handshake; define VIC_RR_EN for round-robin priority
module wbc_vic #(
  parameter int            N        = 4,
  parameter logic [16*N-1:0] VEC    = {16'o074, 16'o070, 16'o064, 16'o060},
  parameter logic [15:0]   SPUR_VEC = 16'o000000
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_n,
  input  logic [N-1:0] ireq,
  output logic         virq,
  input  logic         istb,
  output logic [15:0]  ivec,
  output logic         iack,
  output logic [N-1:0] dev_ack
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, ACK, DONE, HOLD} state_t;
  state_t         r_state, w_state;
  logic           r_virq, w_virq, r_iack, w_iack, r_sel_v, w_sel_v, w_hit;
  logic [15:0]    r_ivec, w_ivec;
  logic [N-1:0]   r_dev_ack, w_dev_ack;
  logic [SW-1:0]  r_sel, w_sel, w_win, w_base;
  logic [SW:0]    w_idx;
`ifdef VIC_RR_EN
  logic [SW-1:0]  r_rr;
  assign w_base = r_rr;
  // advance the round-robin pointer past the source just serviced
  always_ff @(posedge wb_clk_i or negedge wb_rst_n)
    if (!wb_rst_n) r_rr <= '0;
    else if (r_state == DONE && r_sel_v) r_rr <= (r_sel == SW'(N-1)) ? '0 : r_sel + 1'b1;
`else
  assign w_base = '0;
`endif
  // first set request at or after w_base, wrapping modulo N
  always_comb begin
    w_hit = 1'b0;
    w_win = '0;
    w_idx = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = {1'b0, w_base} + (SW+1)'(k);
      if (w_idx >= (SW+1)'(N)) w_idx = w_idx - (SW+1)'(N);
      if (!w_hit && ireq[w_idx[SW-1:0]]) begin
        w_hit = 1'b1;
        w_win = w_idx[SW-1:0];
      end
    end
  end
  // handshake sequencing; all outputs are registered next-values
  always_comb begin
    w_state   = r_state;
    w_virq    = 1'b0;
    w_iack    = r_iack;
    w_ivec    = r_ivec;
    w_sel     = r_sel;
    w_sel_v   = r_sel_v;
    w_dev_ack = '0;
    case (r_state)
      IDLE: if (istb) begin
        w_state = ACK;
        w_iack  = 1'b1;
        w_sel   = w_win;
        w_sel_v = w_hit;
        w_ivec  = w_hit ? VEC[16*w_win +: 16] : SPUR_VEC;
      end else w_virq = |ireq;
      ACK: if (!istb) begin
        w_state   = DONE;
        w_iack    = 1'b0;
        w_ivec    = '0;
        w_dev_ack = r_sel_v ? N'(1) << r_sel : '0;
      end
      DONE: w_state = HOLD;
      default: w_state = IDLE;
    endcase
  end
  // state and output registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_n)
    if (!wb_rst_n) begin
      r_state   <= IDLE;
      r_virq    <= 1'b0;
      r_iack    <= 1'b0;
      r_ivec    <= '0;
      r_sel     <= '0;
      r_sel_v   <= 1'b0;
      r_dev_ack <= '0;
    end else begin
      r_state   <= w_state;
      r_virq    <= w_virq;
      r_iack    <= w_iack;
      r_ivec    <= w_ivec;
      r_sel     <= w_sel;
      r_sel_v   <= w_sel_v;
      r_dev_ack <= w_dev_ack;
    end
  assign virq    = r_virq;
  assign iack    = r_iack;
  assign ivec    = r_ivec;
  assign dev_ack = r_dev_ack;
endmodule
